// File: rtl/parity_seq_pkg.sv
// parity_seq_pkg
//   Shared definitions for the parity-run link transmitter:
//   - state_t           : transmitter FSM states
//   - LFSR_TAPS         : tap mask of the 8-bit Fibonacci scrambler (bits 0,2,3,4)
//   - LFSR_DEFAULT_SEED : default scrambler seed
//   - lfsr_step()       : one right-shift step of the scrambler
package parity_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS         = 8'h1D;
  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

  // Feedback is the XOR of the tapped bits, shifted in at the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {^(l & LFSR_TAPS), l[7:1]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8
//   8-bit Fibonacci LFSR (right shift) with synchronous load and advance.
//   Ports:
//     i_clk     : clock, rising edge
//     i_reset   : asynchronous active-high reset, loads RESET_VAL
//     i_load    : load i_seed
//     i_seed    : value to load (must be nonzero)
//     i_advance : step the register once; combined with i_load the seed is
//                 loaded and stepped in the same cycle
//     o_q       : current register value
module lfsr8
  import parity_seq_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_advance,
  output logic [7:0] o_q
);

  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_base;
  logic [7:0] w_lfsr_next;

  always_comb begin
    w_lfsr_base = i_load ? i_seed : r_lfsr;
    w_lfsr_next = i_advance ? lfsr_step(w_lfsr_base) : w_lfsr_base;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= RESET_VAL;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  assign o_q = r_lfsr;

endmodule

// File: rtl/parity_seq_tx.sv
// parity_seq_tx
//   Serializes a programmed parity pattern onto a 3-wire link, one symbol
//   per clock, such that w1^w2^w3 equals the pattern bit. w1/w2 carry LFSR
//   scrambling bits, w3 restores the wanted parity. Also predicts the
//   downstream run detector output (z after three consecutive odd symbols).
//   Ports:
//     i_clk, i_reset : clock and asynchronous active-high reset
//     i_start        : transfer request, sampled only in IDLE
//     i_pattern      : symbol parities, LSB first, captured on accept
//     i_len          : symbol count 0..PAT_W (larger values clamp to PAT_W)
//     o_busy         : high while symbols are being sent
//     o_done         : one-cycle pulse after the last symbol
//     o_w1/o_w2/o_w3 : registered line symbol
//     o_k_exp        : registered parity of the line symbol
//     o_z_exp        : predicted detector output
module parity_seq_tx
  import parity_seq_pkg::*;
#(
  parameter int         PAT_W     = 16,
  parameter int         LEN_W     = $clog2(PAT_W) + 1,
  parameter logic [7:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_w1,
  output logic             o_w2,
  output logic             o_w3,
  output logic             o_k_exp,
  output logic             o_z_exp
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic             r_w1, r_w2, r_w3, r_k;
  logic [1:0]       r_run;

  state_t           w_state_next;
  logic [PAT_W-1:0] w_pattern_next;
  logic [LEN_W-1:0] w_len_next;
  logic [LEN_W-1:0] w_idx_next;
  logic             w_w1_next, w_w2_next, w_w3_next, w_k_next;
  logic [1:0]       w_run_next;

  logic [LEN_W-1:0] w_len_clamped;
  logic             w_issue;
  logic             w_sym_bit;
  logic [1:0]       w_sym_l;
  logic             w_lfsr_load;
  logic [7:0]       w_lfsr_q;
  logic             w_lfsr_hi_unused;

  // The LFSR always holds the value for the next symbol to be issued. On
  // accept it is loaded and stepped in one go, because symbol 0 itself is
  // built from the seed directly.
  lfsr8 #(
    .RESET_VAL(LFSR_SEED)
  ) u_lfsr (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_lfsr_load),
    .i_seed   (LFSR_SEED),
    .i_advance(w_issue),
    .o_q      (w_lfsr_q)
  );

  // Only the two low bits reach the line; the rest is scrambler state.
  assign w_lfsr_hi_unused = ^w_lfsr_q[7:2];

  assign w_len_clamped = (i_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_len;

  always_comb begin
    w_state_next   = r_state;
    w_pattern_next = r_pattern;
    w_len_next     = r_len;
    w_idx_next     = r_idx;
    w_issue        = 1'b0;
    w_sym_bit      = 1'b0;
    w_sym_l        = w_lfsr_q[1:0];
    w_lfsr_load    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_lfsr_load    = 1'b1;
          w_pattern_next = i_pattern;
          w_len_next     = w_len_clamped;
          w_idx_next     = '0;
          if (w_len_clamped != '0) begin
            w_state_next = ST_SEND;
            w_issue      = 1'b1;
            w_sym_bit    = i_pattern[0];
            w_sym_l      = LFSR_SEED[1:0];
            w_idx_next   = LEN_W'(1);
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        // r_idx is the next symbol to issue; reaching r_len means the last
        // symbol has been on the line for one cycle.
        if (r_idx < r_len) begin
          w_issue    = 1'b1;
          w_sym_bit  = r_pattern[r_idx[IDX_W-1:0]];
          w_idx_next = r_idx + LEN_W'(1);
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Idle symbol is all zeros (even parity).
    w_w1_next = 1'b0;
    w_w2_next = 1'b0;
    w_w3_next = 1'b0;
    w_k_next  = 1'b0;
    if (w_issue) begin
      w_w1_next = w_sym_l[0];
      w_w2_next = w_sym_l[1];
      w_w3_next = w_sym_bit ^ w_sym_l[0] ^ w_sym_l[1];
      w_k_next  = w_sym_bit;
    end

    // Run counter follows the symbol currently on the line, saturating at 3.
    if (r_k) begin
      w_run_next = (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;
    end else begin
      w_run_next = 2'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_w1      <= 1'b0;
      r_w2      <= 1'b0;
      r_w3      <= 1'b0;
      r_k       <= 1'b0;
      r_run     <= 2'd0;
    end else begin
      r_state   <= w_state_next;
      r_pattern <= w_pattern_next;
      r_len     <= w_len_next;
      r_idx     <= w_idx_next;
      r_w1      <= w_w1_next;
      r_w2      <= w_w2_next;
      r_w3      <= w_w3_next;
      r_k       <= w_k_next;
      r_run     <= w_run_next;
    end
  end

  assign o_busy  = (r_state == ST_SEND);
  assign o_done  = (r_state == ST_DONE);
  assign o_w1    = r_w1;
  assign o_w2    = r_w2;
  assign o_w3    = r_w3;
  assign o_k_exp = r_k;
  assign o_z_exp = (r_run == 2'd3);

endmodule

// File: tb/tb_parity_seq_tx.sv
module tb_parity_seq_tx;

  localparam int PAT_W = 16;
  localparam int LEN_W = 5;

  // Hand-derived (w1,w2) for the first 8 symbols after a 0xA5 reseed:
  // A5, 52, A9, 54, 2A, 95, CA, E5 -> {l[0], l[1]}
  localparam logic [1:0] LW [8] = '{2'b10, 2'b01, 2'b10, 2'b00,
                                    2'b01, 2'b10, 2'b01, 2'b10};

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, w1, w2, w3, k_exp, z_exp;

  int errors = 0;
  int checks = 0;

  parity_seq_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .LFSR_SEED(8'hA5)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_pattern(pattern),
    .i_len    (len),
    .o_busy   (busy),
    .o_done   (done),
    .o_w1     (w1),
    .o_w2     (w2),
    .o_w3     (w3),
    .o_k_exp  (k_exp),
    .o_z_exp  (z_exp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {busy, done, w1, w2, w3, k_exp, z_exp};
  endfunction

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: outs=%b want 0000000", outs());
    end
    step();
    step();
    reset = 1'b0;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_release: outs=%b want 0000000", outs());
    end
    $display("tx reset");
  endtask

  // pattern 0x0007, len 3: three 1-symbols, z_exp rises with done.
  task automatic test_run3(input string tag);
    pattern = 16'h0007; len = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, done, w1, w2, k_exp, z_exp} !== {2'b10, LW[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s_sym%0d: busy,done,w1,w2,k,z=%b want %b", tag, i,
                 {busy, done, w1, w2, k_exp, z_exp}, {2'b10, LW[i], 1'b1, 1'b0});
      end
      step();
    end
    checks++;
    if (outs() !== 7'b0100001) begin
      errors++;
      $display("FAIL %s_done: outs=%b want 0100001", tag, outs());
    end
    step();
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL %s_after: outs=%b want 0000000", tag, outs());
    end
    $display("tx %s pattern=0007 len=3", tag);
  endtask

  // pattern 0x00B7, len 8: bits 1,1,1,0,1,1,0,1.
  task automatic test_pattern_b7();
    logic [PAT_W-1:0] p;
    p = 16'h00B7;
    pattern = p; len = 5'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if ({busy, w1, w2, w1 ^ w2 ^ w3, k_exp, z_exp} !==
          {1'b1, LW[j], p[j], p[j], (j == 3)}) begin
        errors++;
        $display("FAIL b7_sym%0d: busy,w1,w2,par,k,z=%b want %b", j,
                 {busy, w1, w2, w1 ^ w2 ^ w3, k_exp, z_exp},
                 {1'b1, LW[j], p[j], p[j], (j == 3)});
      end
      step();
    end
    checks++;
    if (outs() !== 7'b0100000) begin
      errors++;
      $display("FAIL b7_done: outs=%b want 0100000", outs());
    end
    step();
    $display("tx pattern=00B7 len=8");
  endtask

  task automatic test_len_zero();
    pattern = 16'hFFFF; len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (outs() !== 7'b0100000) begin
      errors++;
      $display("FAIL len0_done: outs=%b want 0100000", outs());
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs() !== 7'b0) begin
        errors++;
        $display("FAIL len0_idle%0d: outs=%b want 0000000", i, outs());
      end
    end
    $display("tx pattern=FFFF len=0");
  endtask

  // start held high: the next accept is the first edge seen in IDLE,
  // i.e. DONE then IDLE separate the two transfers.
  task automatic test_back_to_back();
    logic [PAT_W-1:0] p;
    int n;
    p = 16'h0005;
    pattern = p; len = 5'd4; start = 1'b1;
    step();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({busy, w1, w2, k_exp} !== {1'b1, LW[j], p[j]}) begin
        errors++;
        $display("FAIL b2b_sym%0d: busy,w1,w2,k=%b want %b", j,
                 {busy, w1, w2, k_exp}, {1'b1, LW[j], p[j]});
      end
      step();
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: busy,done=%b want 01", {busy, done});
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: busy,done=%b want 00", {busy, done});
    end
    step();
    start = 1'b0;
    checks++;
    if ({busy, w1, w2, k_exp} !== {1'b1, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL b2b_reaccept: busy,w1,w2,k=%b want 1101", {busy, w1, w2, k_exp});
    end
    n = 0;
    while (!done && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL b2b_second_len: cycles_to_done=%0d want 4", n);
    end
    step();
    $display("tx pattern=0005 len=4 back-to-back");
  endtask

  task automatic test_reset_mid();
    pattern = 16'hFFFF; len = 5'd16; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({busy, z_exp} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre: busy,z=%b want 11", {busy, z_exp});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL mid_async: outs=%b want 0000000", outs());
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (outs() !== 7'b0) begin
        errors++;
        $display("FAIL mid_after%0d: outs=%b want 0000000", i, outs());
      end
    end
    $display("tx reset during symbol 5");
    test_run3("postreset");
  endtask

  task automatic test_clamp();
    logic [PAT_W-1:0] p;
    int n;
    p = 16'h9C3A;
    pattern = p; len = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 24 && busy; c++) begin
      checks++;
      if ({w1 ^ w2 ^ w3, k_exp} !== {p[n], p[n]}) begin
        errors++;
        $display("FAIL clamp_sym%0d: par,k=%b want %b", n,
                 {w1 ^ w2 ^ w3, k_exp}, {p[n], p[n]});
      end
      n++;
      step();
    end
    checks++;
    if (n !== 16 || done !== 1'b1) begin
      errors++;
      $display("FAIL clamp_count: symbols=%0d done=%b want 16 1", n, done);
    end
    step();
    $display("tx pattern=9C3A len=20 (clamped)");
  endtask

  initial begin
    test_reset();
    test_run3("run3");
    test_pattern_b7();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
